// File: rtl/mdu_ctrl_pkg.sv
// Shared constants, encodings and small helpers for the RV32M multiply/divide unit.
package mdu_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] M_FUNCT7   = 7'b0000001;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_R_TYPE) && (funct7 == M_FUNCT7);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface mdu_ctrl_if
  import mdu_ctrl_pkg::*;
();

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            stall;
  logic            res_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  stall, res_valid, result
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output stall, res_valid, result
  );

endinterface

// File: rtl/mdu_ctrl_iter.sv
// Radix-2 step datapath: shift-add multiply and restoring shift-subtract divide
// sharing one 2*XLEN accumulator ({hi, lo}).
module mdu_ctrl_iter
  import mdu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   load_lo,
  input  logic [XLEN-1:0]   mcand,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [2*XLEN-1:0] acc_r;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     rem_sh_s;
  logic              ge_s;
  logic [XLEN-1:0]   rem_new_s;

  // Single-step next value; remainder never exceeds XLEN bits after the subtract
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand} : '0);
    rem_sh_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    ge_s      = (rem_sh_s >= {1'b0, divisor});
    if (ge_s) begin
      rem_new_s = rem_sh_s[XLEN-1:0] - divisor;
    end else begin
      rem_new_s = rem_sh_s[XLEN-1:0];
    end
    if (is_div) begin
      acc_nxt = {rem_new_s, acc_r[XLEN-2:0], ge_s};
    end else begin
      acc_nxt = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
    end else if (load) begin
      acc_r <= {{XLEN{1'b0}}, load_lo};
    end else if (step) begin
      acc_r <= acc_nxt;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// RV32M multi-cycle controller: FSM, iteration counter, operand capture,
// sign fix-up and divide special-case bypass around the step datapath.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mdu_ctrl_if.slave bus
);

  mdu_state_e        state_r, state_nxt_s;
  mdu_op_e           op_r, op_in_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              sign_a_r, sign_b_r;
  logic [XLEN-1:0]   a_mag_r, b_mag_r, result_r;
  logic              a_signed_s, b_signed_s, sign_a_in_s, sign_b_in_s;
  logic [XLEN-1:0]   a_mag_in_s, b_mag_in_s, load_lo_s;
  logic [XLEN-1:0]   special_res_s, final_res_s, quo_s, rem_s;
  logic              div_zero_s, div_ovf_s, special_s, iter_div_s;
  logic              load_s, step_s, finish_s, bypass_s, stall_s, res_valid_s;
  logic [2*XLEN-1:0] acc_nxt_s, prod_s;

  assign op_in_s = mdu_op_e'(bus.funct3);

  // Operand signedness of the incoming op
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (op_in_s)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      MDU_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
  end

  assign sign_a_in_s = a_signed_s & bus.src_a[XLEN-1];
  assign sign_b_in_s = b_signed_s & bus.src_b[XLEN-1];
  assign a_mag_in_s  = sign_a_in_s ? -bus.src_a : bus.src_a;
  assign b_mag_in_s  = sign_b_in_s ? -bus.src_b : bus.src_b;
  assign load_lo_s   = is_div_op(op_in_s) ? a_mag_in_s : b_mag_in_s;

  assign div_zero_s = (bus.src_b == '0);
  assign div_ovf_s  = ((op_in_s == MDU_DIV) || (op_in_s == MDU_REM)) &&
                      (bus.src_a == INT_MIN) && (bus.src_b == '1);
  assign special_s  = is_div_op(op_in_s) & (div_zero_s | div_ovf_s);

  // Bypass result; divide-by-zero wins over overflow (MIN / 0)
  always_comb begin
    special_res_s = '0;
    case (op_in_s)
      MDU_DIV, MDU_DIVU: begin
        if (div_zero_s) special_res_s = '1;
        else            special_res_s = INT_MIN;
      end
      MDU_REM, MDU_REMU: begin
        if (div_zero_s) special_res_s = bus.src_a;
        else            special_res_s = '0;
      end
      default: special_res_s = '0;
    endcase
  end

  // FSM next state and control strobes; flush dominates every state
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    res_valid_s = 1'b0;
    load_s      = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    bypass_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          stall_s = 1'b1;
          load_s  = 1'b1;
          if (special_s) begin
            bypass_s    = 1'b1;
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        stall_s = 1'b1;
        if (bus.flush) begin
          state_nxt_s = IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == '0) begin
            finish_s    = 1'b1;
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        if (bus.flush) res_valid_s = 1'b0;
        else           res_valid_s = 1'b1;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand, opcode and sign-flag capture at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= MDU_MUL;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      a_mag_r  <= '0;
      b_mag_r  <= '0;
    end else if (load_s) begin
      op_r     <= op_in_s;
      sign_a_r <= sign_a_in_s;
      sign_b_r <= sign_b_in_s;
      a_mag_r  <= a_mag_in_s;
      b_mag_r  <= b_mag_in_s;
    end
  end

  // Iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load_s) begin
      cnt_r <= CNT_INIT;
    end else if (step_s && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  assign iter_div_s = is_div_op(op_r);

  mdu_ctrl_iter u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .step    (step_s),
    .is_div  (iter_div_s),
    .load_lo (load_lo_s),
    .mcand   (a_mag_r),
    .divisor (b_mag_r),
    .acc_nxt (acc_nxt_s)
  );

  // Sign fix-up is applied to the value produced by the last step
  assign prod_s = (sign_a_r ^ sign_b_r) ? -acc_nxt_s : acc_nxt_s;
  assign quo_s  = (sign_a_r ^ sign_b_r) ? -acc_nxt_s[XLEN-1:0] : acc_nxt_s[XLEN-1:0];
  assign rem_s  = sign_a_r ? -acc_nxt_s[2*XLEN-1:XLEN] : acc_nxt_s[2*XLEN-1:XLEN];

  // Final result selection
  always_comb begin
    final_res_s = '0;
    case (op_r)
      MDU_MUL:                         final_res_s = prod_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res_s = prod_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               final_res_s = quo_s;
      MDU_REM, MDU_REMU:               final_res_s = rem_s;
      default:                         final_res_s = '0;
    endcase
  end

  // Result register, loaded on entry to DONE and held until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
    end else if (bypass_s) begin
      result_r <= special_res_s;
    end else if (finish_s) begin
      result_r <= final_res_s;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.res_valid = res_valid_s;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  mdu_ctrl_if bus();

  mdu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one op at a negedge and hold start until DONE; flush_cyc >= 0 kills it
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_cyc);
    bit          got, spec;
    int          stall_cnt, vcyc, lat, exp_stall;
    logic [31:0] res, exp;
    exp  = ref_result(op, a, b);
    spec = op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    lat  = spec ? 1 : XLEN + 1;
    bus.start  = 1'b1;
    bus.funct3 = op;
    bus.src_a  = a;
    bus.src_b  = b;
    got = 1'b0; stall_cnt = 0; vcyc = -1; res = 32'd0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == flush_cyc) begin
        bus.flush = 1'b1;
        bus.start = 1'b0;
      end else begin
        bus.flush = 1'b0;
      end
      #1;
      if (bus.stall) stall_cnt++;
      if (bus.res_valid && !got) begin
        got = 1'b1; res = bus.result; vcyc = cyc;
      end
      @(negedge clk);
      if (got && flush_cyc < 0) break;
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    if (flush_cyc < 0) begin
      exp_stall = lat;
      check_eq($sformatf("valid op%0d", op), 32'(got), 32'd1);
      check_eq($sformatf("result op%0d a=%h b=%h", op, a, b), res, exp);
      check_eq($sformatf("latency op%0d", op), 32'(vcyc), 32'(lat));
    end else begin
      exp_stall = (flush_cyc < lat) ? flush_cyc + 1 : lat;
      check_eq($sformatf("flushed valid cyc%0d", flush_cyc), 32'(got), 32'd0);
    end
    check_eq($sformatf("stall cycles op%0d", op), 32'(stall_cnt), 32'(exp_stall));
    #1;
    check_eq("post stall", 32'(bus.stall), 32'd0);
    check_eq("post valid", 32'(bus.res_valid), 32'd0);
    if (flush_cyc < 0) check_eq("result hold", bus.result, exp);
    @(negedge clk);
  endtask

  initial begin
    int          nv;
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
    bus.src_a = 32'd0; bus.src_b = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset stall", 32'(bus.stall), 32'd0);
    check_eq("reset valid", 32'(bus.res_valid), 32'd0);
    check_eq("reset result", bus.result, 32'd0);
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd5, 32'd100, 32'd7, -1);
    run_op(3'd7, 32'd100, 32'd7, -1);
    run_op(3'd5, 32'd5, 32'd0, -1);
    run_op(3'd6, 32'd5, 32'd0, -1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);

    // Kill in CALC cycle 10, then a fresh MUL; also kill in DONE
    run_op(3'd0, 32'h1234_5678, 32'h0000_0099, 10);
    run_op(3'd0, 32'h0000_0123, 32'hFFFF_FF00, -1);
    run_op(3'd3, 32'hDEAD_BEEF, 32'h0000_1001, XLEN + 1);

    // Reset mid-CALC discards the op
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.src_a = 32'd9; bus.src_b = 32'd9;
    repeat (10) @(negedge clk);
    rst = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst mid stall", 32'(bus.stall), 32'd0);
    check_eq("rst mid valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst mid result", bus.result, 32'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (bus.res_valid || bus.stall) nv++;
    end
    check_eq("rst mid quiet", 32'(nv), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        4: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
